// File: rtl/i2c_mem_arb.sv
// i2c_mem_arb: round-robin arbiter granting two requesters access to an I2C memory master.
module i2c_mem_arb #(
  parameter int TIMEOUT = 4095
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       wr0,
  input  logic       wr1,
  input  logic [6:0] addr0,
  input  logic [6:0] addr1,
  input  logic [7:0] din0,
  input  logic [7:0] din1,
  output logic [1:0] gnt,
  output logic [1:0] ack,
  output logic       err,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       mem_req,
  output logic       mem_wr,
  output logic [6:0] mem_addr,
  output logic [7:0] mem_din,
  input  logic       mem_done,
  input  logic [7:0] mem_datard
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state, nxt;
  logic sel, last, lwr, flag, pick, tmo;
  logic [6:0] laddr;
  logic [7:0] ldin, rd;
  logic [15:0] timer;
  assign pick = (req == 2'b11) ? ~last : req[1];
  assign tmo = timer == 16'(TIMEOUT - 1);
  assign rdata = rd;
  always_ff @(posedge clk)
    state <= rst ? IDLE : nxt;
  always_comb
    nxt = state == IDLE ? (|req ? BUSY : IDLE) :
          state == BUSY ? ((mem_done || tmo) ? RESP : BUSY) : IDLE;
  // last resets to 1 so that requester 0 wins the first contention
  always_ff @(posedge clk) begin
    if (rst) begin
      sel <= 1'b0;
      last <= 1'b1;
      lwr <= 1'b0;
      laddr <= '0;
      ldin <= '0;
      timer <= '0;
      flag <= 1'b0;
      rd <= '0;
    end else begin
      if (state == IDLE && |req) begin
        sel <= pick;
        lwr <= pick ? wr1 : wr0;
        laddr <= pick ? addr1 : addr0;
        ldin <= pick ? din1 : din0;
        timer <= '0;
        flag <= 1'b0;
      end
      if (state == BUSY) begin
        timer <= timer + 16'd1;
        if (mem_done) begin
          flag <= 1'b0;
          if (!lwr) rd <= mem_datard;
        end else if (tmo) flag <= 1'b1;
      end
      if (state == RESP) last <= sel;
    end
  end
  always_comb begin
    busy = state != IDLE;
    mem_req = state == BUSY;
    gnt = mem_req ? (sel ? 2'b10 : 2'b01) : 2'b00;
    ack = state == RESP ? (sel ? 2'b10 : 2'b01) : 2'b00;
    err = state == RESP && flag;
    mem_wr = mem_req && lwr;
    mem_addr = mem_req ? laddr : 7'd0;
    mem_din = mem_req ? ldin : 8'd0;
  end
endmodule

// File: tb/tb_i2c_mem_arb.sv
// tb_i2c_mem_arb: directed self-checking bench for i2c_mem_arb with TIMEOUT=8.
module tb_i2c_mem_arb;
  logic clk = 1'b0, rst, wr0, wr1, err, busy, mem_req, mem_wr, mem_done;
  logic [1:0] req, gnt, ack;
  logic [6:0] addr0, addr1, mem_addr;
  logic [7:0] din0, din1, rdata, mem_din, mem_datard;
  int checks = 0, errors = 0;
  i2c_mem_arb #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .req(req), .wr0(wr0), .wr1(wr1), .addr0(addr0), .addr1(addr1),
    .din0(din0), .din1(din1), .gnt(gnt), .ack(ack), .err(err), .rdata(rdata), .busy(busy),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_done(mem_done), .mem_datard(mem_datard)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    rst = 1'b1; req = 2'b00; wr0 = 1'b0; wr1 = 1'b0; addr0 = '0; addr1 = '0;
    din0 = '0; din1 = '0; mem_done = 1'b0; mem_datard = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_gnt", gnt, 2'b00); chk("rst_ack", ack, 2'b00); chk("rst_err", err, 0);
    chk("rst_rdata", rdata, 8'h00); chk("rst_busy", busy, 0); chk("rst_memreq", mem_req, 0);
    chk("rst_memaddr", mem_addr, 7'h00); chk("rst_memdin", mem_din, 8'h00);
    // write 0xA5 to 0x15 via requester 0
    req = 2'b01; wr0 = 1'b1; addr0 = 7'h15; din0 = 8'hA5;
    tick();
    chk("wr_gnt", gnt, 2'b01); chk("wr_memreq", mem_req, 1); chk("wr_memwr", mem_wr, 1);
    chk("wr_addr", mem_addr, 7'h15); chk("wr_din", mem_din, 8'hA5); chk("wr_busy", busy, 1);
    req = 2'b00; mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    chk("wr_ack", ack, 2'b01); chk("wr_err", err, 0); chk("wr_gnt_clr", gnt, 2'b00);
    chk("wr_rdata_hold", rdata, 8'h00);
    tick();
    chk("wr_ack_pulse", ack, 2'b00); chk("wr_idle", busy, 0);
    // read it back
    req = 2'b01; wr0 = 1'b0;
    tick();
    chk("rd_memwr", mem_wr, 0); chk("rd_addr", mem_addr, 7'h15);
    req = 2'b00; mem_done = 1'b1; mem_datard = 8'hA5;
    tick();
    mem_done = 1'b0;
    chk("rd_ack", ack, 2'b01); chk("rd_rdata", rdata, 8'hA5); chk("rd_err", err, 0);
    tick();
    // contention after reset: 0,1,0,1
    rst = 1'b1; tick(); rst = 1'b0;
    req = 2'b11; wr1 = 1'b0; mem_datard = 8'h5A;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("cont_gnt", gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
      mem_done = 1'b1;
      tick();
      mem_done = 1'b0;
      chk("cont_ack", ack, (i % 2 == 0) ? 2'b01 : 2'b10);
      tick();
      chk("cont_ack_once", ack, 2'b00);
    end
    req = 2'b00;
    chk("cont_rdata", rdata, 8'h5A);
    // latched address is immune to later requester changes
    req = 2'b01; wr0 = 1'b1; addr0 = 7'h10; din0 = 8'h11;
    tick();
    chk("stab_addr0", mem_addr, 7'h10);
    addr0 = 7'h7F; din0 = 8'hEE; wr0 = 1'b0;
    tick();
    chk("stab_addr1", mem_addr, 7'h10); chk("stab_din", mem_din, 8'h11); chk("stab_wr", mem_wr, 1);
    tick();
    chk("stab_addr2", mem_addr, 7'h10);
    req = 2'b00; mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    chk("stab_ack", ack, 2'b01); chk("stab_rdata", rdata, 8'h5A);
    tick();
    // timeout on a read by requester 1
    req = 2'b10; wr1 = 1'b0; addr1 = 7'h03; mem_datard = 8'hC3;
    tick();
    chk("to_gnt", gnt, 2'b10);
    req = 2'b00;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("to_noack", ack, 2'b00);
    end
    tick();
    chk("to_ack", ack, 2'b10); chk("to_err", err, 1); chk("to_rdata", rdata, 8'h5A);
    tick();
    chk("to_err_pulse", err, 0); chk("to_idle", busy, 0);
    // mem_done coincident with timeout wins
    req = 2'b01; wr0 = 1'b0; addr0 = 7'h22;
    tick();
    chk("co_gnt", gnt, 2'b01);
    req = 2'b00;
    for (int i = 0; i < 7; i++) tick();
    chk("co_busy", busy, 1);
    mem_done = 1'b1; mem_datard = 8'h3C;
    tick();
    mem_done = 1'b0;
    chk("co_ack", ack, 2'b01); chk("co_err", err, 0); chk("co_rdata", rdata, 8'h3C);
    tick();
    mem_done = 1'b1; mem_datard = 8'h99;
    tick();
    mem_done = 1'b0;
    chk("stray_busy", busy, 0); chk("stray_ack", ack, 2'b00); chk("stray_rdata", rdata, 8'h3C);
    // reset in the middle of a read
    req = 2'b01;
    tick();
    chk("rb_busy", busy, 1);
    req = 2'b00; rst = 1'b1;
    tick();
    rst = 1'b0; mem_done = 1'b1; mem_datard = 8'hFF;
    tick();
    mem_done = 1'b0;
    chk("rb_ack", ack, 2'b00); chk("rb_err", err, 0); chk("rb_gnt", gnt, 2'b00);
    chk("rb_busy0", busy, 0); chk("rb_rdata", rdata, 8'h00); chk("rb_memreq", mem_req, 0);
    chk("rb_memaddr", mem_addr, 7'h00);
    req = 2'b10;
    tick();
    chk("rb_gnt1", gnt, 2'b10);
    req = 2'b00; mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    chk("rb_ack1", ack, 2'b10);
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
